// File: rtl/regfifo_push_arbiter.sv
// Round-robin, packet-locked arbiter sharing one register-FIFO push port among NUM_REQ producers.
// Optional lock watchdog is built when REGFIFO_ARB_TIMEOUT_EN is defined.
module regfifo_push_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 60,
  parameter int DEPTH_W = 4
) (
  input  logic                      clockCore,
  input  logic                      resetCore,
  input  logic [NUM_REQ-1:0]        reqValid,
  input  logic [NUM_REQ-1:0]        reqLast,
  input  logic [NUM_REQ*DATA_W-1:0] reqData,
  output logic [NUM_REQ-1:0]        reqReady,
  output logic                      fifoPush,
  output logic [DATA_W-1:0]         fifoDataIn,
  input  logic                      fifoFull,
  input  logic                      fifoAlmostFull,
  input  logic                      fifoOverrun,
  input  logic [DEPTH_W-1:0]        cfgAfThreshold,
  output logic [DEPTH_W-1:0]        fifoAfThreshold,
  output logic [2:0]                grantId,
  output logic                      busy,
  output logic                      errOverrun,
  output logic                      errTimeout,
  input  logic                      errClear
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [2:0]         rr_ptr_q, rr_ptr_d;
  logic [2:0]         grant_q, grant_d;
  logic [DEPTH_W-1:0] thr_q;
  logic               err_ovr_q;
  logic [7:0]         valid_pad, last_pad;
  logic [DATA_W-1:0]  data_arr [8];
  logic [2:0]         win_idx;
  logic [2:0]         rr_after_owner;
  logic               in_lock, beat_acc, pkt_done, wd_expire;

  assign valid_pad = 8'(reqValid);
  assign last_pad  = 8'(reqLast);

  // Fixed 8-entry view of the data bus so the 3-bit owner index always selects in range.
  for (genvar gi = 0; gi < 8; gi++) begin : g_slice
    if (gi < NUM_REQ) begin : g_real
      assign data_arr[gi] = reqData[gi*DATA_W +: DATA_W];
      assign reqReady[gi] = beat_acc & (grant_q == 3'(gi));
    end else begin : g_pad
      assign data_arr[gi] = '0;
    end
  end

  assign in_lock  = (state_q == LOCK);
  assign beat_acc = in_lock & valid_pad[grant_q] & ~fifoFull;
  assign pkt_done = beat_acc & last_pad[grant_q];

  assign fifoPush        = beat_acc;
  assign fifoDataIn      = resetCore ? data_arr[grant_q] : '0;
  assign fifoAfThreshold = thr_q;
  assign grantId         = grant_q;
  assign busy            = in_lock;
  assign errOverrun      = err_ovr_q;

  function automatic logic [2:0] wrap_add(input logic [2:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return 3'(s);
  endfunction

  // Walk offsets from high to low so the smallest offset from rr_ptr_q wins.
  always_comb begin
    win_idx = rr_ptr_q;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (valid_pad[wrap_add(rr_ptr_q, k)]) win_idx = wrap_add(rr_ptr_q, k);
    end
  end

  assign rr_after_owner = (grant_q == 3'(NUM_REQ - 1)) ? 3'd0 : grant_q + 3'd1;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    case (state_q)
      IDLE: begin
        if ((|reqValid) && !fifoAlmostFull) begin
          grant_d = win_idx;
          state_d = LOCK;
        end
      end
      default: begin
        if (pkt_done || wd_expire) begin
          state_d  = IDLE;
          rr_ptr_d = rr_after_owner;
        end
      end
    endcase
  end

  always_ff @(posedge clockCore or negedge resetCore) begin
    if (!resetCore) begin
      state_q   <= IDLE;
      rr_ptr_q  <= 3'd0;
      grant_q   <= 3'd0;
      thr_q     <= '0;
      err_ovr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      thr_q    <= cfgAfThreshold;
      if (fifoOverrun)   err_ovr_q <= 1'b1;
      else if (errClear) err_ovr_q <= 1'b0;
    end
  end

`ifdef REGFIFO_ARB_TIMEOUT_EN
  logic [15:0] wd_q, wd_d;
  logic        err_to_q;

  assign wd_expire  = in_lock & ~beat_acc & (wd_q == 16'hFFFF);
  assign errTimeout = err_to_q;

  always_comb begin
    wd_d = 16'd0;
    if (in_lock && !beat_acc && !wd_expire) wd_d = wd_q + 16'd1;
  end

  always_ff @(posedge clockCore or negedge resetCore) begin
    if (!resetCore) begin
      wd_q     <= 16'd0;
      err_to_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      if (wd_expire)     err_to_q <= 1'b1;
      else if (errClear) err_to_q <= 1'b0;
    end
  end
`else
  assign wd_expire  = 1'b0;
  assign errTimeout = 1'b0;
`endif

endmodule
